// File: rtl/id_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
// Shared constants for the decode stage: instruction mode codes, ARM data
// processing opcodes, condition codes, ALU command encodings and the packed
// control-bundle type produced by the control decoder.
// No ports (package).
// ----------------------------------------------------------------------------
package id_pkg;

    // Instruction class, bits [27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_NOP = 2'b11;

    // Data processing opcodes, bits [24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Condition codes, bits [31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ALU command encodings seen by the EX stage
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_MOV  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADC  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SBC  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ORR  = 4'b0111;
    localparam logic [3:0] ALU_EOR  = 4'b1000;
    localparam logic [3:0] ALU_MVN  = 4'b1001;

    // Control bundle produced by the decoder
    typedef struct packed {
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       status_en;
        logic [3:0] alu_cmd;
    } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// ----------------------------------------------------------------------------
// id_regfile
// NUM_REGS x DATA_W register file with two combinational read ports and one
// synchronous write port. A read of the register being written in the same
// cycle returns the incoming write data (write-through), so the decode stage
// never sees a stale value from the WB stage.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset, clears every entry
//   wb_en_i      write enable
//   wb_dest_i    write address
//   wb_data_i    write data
//   rd_addr1_i   read port 1 address,  rd_data1_o read port 1 data
//   rd_addr2_i   read port 2 address,  rd_data2_o read port 2 data
// ----------------------------------------------------------------------------
module id_regfile #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_en_i,
    input  logic [RA_W-1:0]   wb_dest_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [RA_W-1:0]   rd_addr1_i,
    input  logic [RA_W-1:0]   rd_addr2_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i) begin
            regs_q[wb_dest_i] <= wb_data_i;
        end
    end

    // Write-through bypass on both read ports
    always_comb begin
        rd_data1_o = regs_q[rd_addr1_i];
        rd_data2_o = regs_q[rd_addr2_i];
        if (wb_en_i && (wb_dest_i == rd_addr1_i)) begin
            rd_data1_o = wb_data_i;
        end
        if (wb_en_i && (wb_dest_i == rd_addr2_i)) begin
            rd_data2_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ----------------------------------------------------------------------------
// id_stage_pipe
// Decode stage with its ID/EX pipeline register. Decodes an ARM-style
// instruction, evaluates its condition against {N,Z,C,V}, reads operands from
// the register file (write-through from WB), detects RAW hazards against the
// EX and MEM stages and loads the ID/EX register with either the decoded
// instruction or a bubble. One cycle from instruction to ie_* outputs.
//
// Configuration macro: FWD_EN
//   undefined: stall on any used source matching a writing EX or MEM dest.
//   defined:   stall only on load-use against EX; everything else is left
//              to the downstream forwarding unit (ie_src1/ie_src2).
//
// Ports:
//   clk, rst (async active-low)
//   flush            squash the instruction currently in decode
//   in_valid, pc_in, instruction, status   IF/ID inputs and flags
//   wb_en_in, wb_dest, wb_data             register file write port
//   ex_wb_en, ex_mem_read, ex_dest         instruction in EX
//   mem_wb_en, mem_dest                    instruction in MEM
//   hazard_stall     combinational stall request to IF and IF/ID
//   ie_*             registered ID/EX outputs
// ----------------------------------------------------------------------------
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instruction,
    input  logic [3:0]        status,
    input  logic              wb_en_in,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_wb_en,
    input  logic              ex_mem_read,
    input  logic [RA_W-1:0]   ex_dest,
    input  logic              mem_wb_en,
    input  logic [RA_W-1:0]   mem_dest,
    output logic              hazard_stall,
    output logic              ie_valid,
    output logic              ie_wb_en,
    output logic              ie_mem_read,
    output logic              ie_mem_write,
    output logic              ie_branch,
    output logic              ie_status_en,
    output logic              ie_imm,
    output logic [3:0]        ie_alu_cmd,
    output logic [DATA_W-1:0] ie_pc,
    output logic [DATA_W-1:0] ie_reg1,
    output logic [DATA_W-1:0] ie_reg2,
    output logic [RA_W-1:0]   ie_dest,
    output logic [RA_W-1:0]   ie_src1,
    output logic [RA_W-1:0]   ie_src2,
    output logic [23:0]       ie_simm24,
    output logic [11:0]       ie_shift_op
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              status_en;
        logic              imm;
        logic [3:0]        alu_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [RA_W-1:0]   dest;
        logic [RA_W-1:0]   src1;
        logic [RA_W-1:0]   src2;
        logic [23:0]       simm24;
        logic [11:0]       shift_op;
    } idex_t;

    // ------------------------------------------------------------------
    // Condition evaluation on {N,Z,C,V}; NV (1111) never executes.
    // ------------------------------------------------------------------
    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [3:0] nzcv);
        logic n, z, c, v;
        logic ok;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = ~z;
            COND_CS: ok = c;
            COND_CC: ok = ~c;
            COND_MI: ok = n;
            COND_PL: ok = ~n;
            COND_VS: ok = v;
            COND_VC: ok = ~v;
            COND_HI: ok = c & ~z;
            COND_LS: ok = ~c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = ~z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Control decode from mode / opcode / S.
    // ------------------------------------------------------------------
    function automatic ctrl_t decode_ctrl(input logic [1:0] mode,
                                          input logic [3:0] opcode,
                                          input logic       s_bit);
        ctrl_t c;
        c = '0;
        case (mode)
            MODE_DP: begin
                c.wb_en     = 1'b1;
                c.status_en = s_bit;
                case (opcode)
                    OP_AND: c.alu_cmd = ALU_AND;
                    OP_EOR: c.alu_cmd = ALU_EOR;
                    OP_SUB: c.alu_cmd = ALU_SUB;
                    OP_ADD: c.alu_cmd = ALU_ADD;
                    OP_ADC: c.alu_cmd = ALU_ADC;
                    OP_SBC: c.alu_cmd = ALU_SBC;
                    OP_ORR: c.alu_cmd = ALU_ORR;
                    OP_MOV: c.alu_cmd = ALU_MOV;
                    OP_MVN: c.alu_cmd = ALU_MVN;
                    OP_TST: begin
                        c.alu_cmd = ALU_AND;
                        c.wb_en   = 1'b0;
                    end
                    OP_CMP: begin
                        c.alu_cmd = ALU_SUB;
                        c.wb_en   = 1'b0;
                    end
                    default: c = '0;
                endcase
            end
            MODE_MEM: begin
                c.alu_cmd = ALU_ADD;
                if (s_bit) begin
                    c.mem_read = 1'b1;
                    c.wb_en    = 1'b1;
                end else begin
                    c.mem_write = 1'b1;
                end
            end
            MODE_BR: c.branch = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [3:0]      f_cond;
    logic [1:0]      f_mode;
    logic            f_i;
    logic [3:0]      f_opcode;
    logic            f_s;
    logic [RA_W-1:0] f_rn;
    logic [RA_W-1:0] f_rd;
    logic [RA_W-1:0] f_rm;
    logic            is_str;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
    logic            use_src1;
    logic            use_src2;

    assign f_cond   = instruction[31:28];
    assign f_mode   = instruction[27:26];
    assign f_i      = instruction[25];
    assign f_opcode = instruction[24:21];
    assign f_s      = instruction[20];
    assign f_rn     = RA_W'(instruction[19:16]);
    assign f_rd     = RA_W'(instruction[15:12]);
    assign f_rm     = RA_W'(instruction[3:0]);

    assign is_str   = (f_mode == MODE_MEM) && !f_s;
    assign src1     = f_rn;
    // STR reads the value to store from Rd
    assign src2     = is_str ? f_rd : f_rm;

    assign use_src1 = !((f_mode == MODE_DP) &&
                        ((f_opcode == OP_MOV) || (f_opcode == OP_MVN))) &&
                      (f_mode != MODE_BR);
    assign use_src2 = ((f_mode == MODE_DP) && !f_i) || is_str;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    id_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i      (clk),
        .rst_ni     (rst),
        .wb_en_i    (wb_en_in),
        .wb_dest_i  (wb_dest),
        .wb_data_i  (wb_data),
        .rd_addr1_i (src1),
        .rd_addr2_i (src2),
        .rd_data1_o (rd_data1),
        .rd_data2_o (rd_data2)
    );

    // ------------------------------------------------------------------
    // Hazard detection. flush masks the stall: a squashed instruction
    // must not hold IF.
    // ------------------------------------------------------------------
    logic hz;

`ifdef FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_wb_en, mem_wb_en, mem_dest};

    assign hz = in_valid && !flush && ex_mem_read &&
                ((use_src1 && (src1 == ex_dest)) ||
                 (use_src2 && (src2 == ex_dest)));
`else
    logic ex_hit;
    logic mem_hit;
    logic unused_nofwd;
    assign unused_nofwd = ex_mem_read;

    assign ex_hit  = ex_wb_en &&
                     ((use_src1 && (src1 == ex_dest)) ||
                      (use_src2 && (src2 == ex_dest)));
    assign mem_hit = mem_wb_en &&
                     ((use_src1 && (src1 == mem_dest)) ||
                      (use_src2 && (src2 == mem_dest)));
    assign hz      = in_valid && !flush && (ex_hit || mem_hit);
`endif

    assign hazard_stall = hz;

    // ------------------------------------------------------------------
    // ID/EX next state. Any of flush / hazard / empty slot yields an
    // all-zero bubble; a failed condition keeps the data fields and
    // ie_valid but zeroes the controls.
    // ------------------------------------------------------------------
    ctrl_t ctrl_raw;
    ctrl_t ctrl_eff;
    idex_t idex_d;
    idex_t idex_q;

    assign ctrl_raw = decode_ctrl(f_mode, f_opcode, f_s);
    assign ctrl_eff = cond_pass(f_cond, status) ? ctrl_raw : '0;

    always_comb begin
        idex_d = '0;
        if (!flush && !hz && in_valid) begin
            idex_d.valid     = 1'b1;
            idex_d.wb_en     = ctrl_eff.wb_en;
            idex_d.mem_read  = ctrl_eff.mem_read;
            idex_d.mem_write = ctrl_eff.mem_write;
            idex_d.branch    = ctrl_eff.branch;
            idex_d.status_en = ctrl_eff.status_en;
            idex_d.alu_cmd   = ctrl_eff.alu_cmd;
            idex_d.imm       = f_i;
            idex_d.pc        = pc_in;
            idex_d.reg1      = rd_data1;
            idex_d.reg2      = rd_data2;
            idex_d.dest      = f_rd;
            idex_d.src1      = src1;
            idex_d.src2      = src2;
            idex_d.simm24    = instruction[23:0];
            idex_d.shift_op  = instruction[11:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ie_valid     = idex_q.valid;
    assign ie_wb_en     = idex_q.wb_en;
    assign ie_mem_read  = idex_q.mem_read;
    assign ie_mem_write = idex_q.mem_write;
    assign ie_branch    = idex_q.branch;
    assign ie_status_en = idex_q.status_en;
    assign ie_imm       = idex_q.imm;
    assign ie_alu_cmd   = idex_q.alu_cmd;
    assign ie_pc        = idex_q.pc;
    assign ie_reg1      = idex_q.reg1;
    assign ie_reg2      = idex_q.reg2;
    assign ie_dest      = idex_q.dest;
    assign ie_src1      = idex_q.src1;
    assign ie_src2      = idex_q.src2;
    assign ie_simm24    = idex_q.simm24;
    assign ie_shift_op  = idex_q.shift_op;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed bench for id_stage_pipe. Hand-encoded instructions with
// hand-computed expectations. Build with +define+FWD_EN to exercise the
// forwarding variant; expectations that differ are selected per build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_stage_pipe;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int RA_W     = 4;

`ifdef FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    // Hand-encoded instructions
    localparam logic [31:0] I_ADD_R1_R2_R3 = 32'hE082_1003;
    localparam logic [31:0] I_SUB_R4_R3_R5 = 32'hE043_4005;
    localparam logic [31:0] I_MOVEQ_R1_5   = 32'h03A0_1005;
    localparam logic [31:0] I_ADDNV        = 32'hF082_1003;
    localparam logic [31:0] I_TSTS_R1_R2   = 32'hE111_0002;
    localparam logic [31:0] I_STR_R7_R2    = 32'hE582_7000;
    localparam logic [31:0] I_LDR_R7_R2    = 32'hE592_7000;
    localparam logic [31:0] I_B_10         = 32'hEA00_0010;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       instruction;
    logic [3:0]        status;
    logic              wb_en_in;
    logic [RA_W-1:0]   wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [RA_W-1:0]   ex_dest;
    logic              mem_wb_en;
    logic [RA_W-1:0]   mem_dest;
    logic              hazard_stall;
    logic              ie_valid;
    logic              ie_wb_en;
    logic              ie_mem_read;
    logic              ie_mem_write;
    logic              ie_branch;
    logic              ie_status_en;
    logic              ie_imm;
    logic [3:0]        ie_alu_cmd;
    logic [DATA_W-1:0] ie_pc;
    logic [DATA_W-1:0] ie_reg1;
    logic [DATA_W-1:0] ie_reg2;
    logic [RA_W-1:0]   ie_dest;
    logic [RA_W-1:0]   ie_src1;
    logic [RA_W-1:0]   ie_src2;
    logic [23:0]       ie_simm24;
    logic [11:0]       ie_shift_op;

    int n_checks;
    int n_errors;

    id_stage_pipe #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .pc_in        (pc_in),
        .instruction  (instruction),
        .status       (status),
        .wb_en_in     (wb_en_in),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .ex_dest      (ex_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .hazard_stall (hazard_stall),
        .ie_valid     (ie_valid),
        .ie_wb_en     (ie_wb_en),
        .ie_mem_read  (ie_mem_read),
        .ie_mem_write (ie_mem_write),
        .ie_branch    (ie_branch),
        .ie_status_en (ie_status_en),
        .ie_imm       (ie_imm),
        .ie_alu_cmd   (ie_alu_cmd),
        .ie_pc        (ie_pc),
        .ie_reg1      (ie_reg1),
        .ie_reg2      (ie_reg2),
        .ie_dest      (ie_dest),
        .ie_src1      (ie_src1),
        .ie_src2      (ie_src2),
        .ie_simm24    (ie_simm24),
        .ie_shift_op  (ie_shift_op)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flush       = 1'b0;
        in_valid    = 1'b0;
        pc_in       = '0;
        instruction = '0;
        status      = 4'b0000;
        wb_en_in    = 1'b0;
        wb_dest     = '0;
        wb_data     = '0;
        ex_wb_en    = 1'b0;
        ex_mem_read = 1'b0;
        ex_dest     = '0;
        mem_wb_en   = 1'b0;
        mem_dest    = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [DATA_W-1:0] pc);
        in_valid    = 1'b1;
        instruction = instr;
        pc_in       = pc;
    endtask

    task automatic write_back(input logic [RA_W-1:0] dst, input logic [DATA_W-1:0] dat);
        wb_en_in = 1'b1;
        wb_dest  = dst;
        wb_data  = dat;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        check("reset_valid", 32'(ie_valid), 32'h0);
        check("reset_stall", 32'(hazard_stall), 32'h0);
        rst = 1'b1;

        // Load an instruction with R2 written through, then reset mid-stream
        issue(I_ADD_R1_R2_R3, 32'h104);
        write_back(4'd2, 32'hBEEF);
        tick();
        check("pre_rst_valid", 32'(ie_valid), 32'h1);
        check("pre_rst_reg1_wt", ie_reg1, 32'hBEEF);
        check("pre_rst_pc", ie_pc, 32'h104);
        wb_en_in = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(ie_valid), 32'h0);
        check("midrst_alu", 32'(ie_alu_cmd), 32'h0);
        check("midrst_reg1", ie_reg1, 32'h0);
        check("midrst_pc", ie_pc, 32'h0);
        #2;
        rst = 1'b1;

        // ADD R1,R2,R3 after reset: R2 must have been cleared
        issue(I_ADD_R1_R2_R3, 32'h108);
        tick();
        check("add_alu", 32'(ie_alu_cmd), 32'h2);
        check("add_wb", 32'(ie_wb_en), 32'h1);
        check("add_dest", 32'(ie_dest), 32'h1);
        check("add_valid", 32'(ie_valid), 32'h1);
        check("add_src1", 32'(ie_src1), 32'h2);
        check("add_src2", 32'(ie_src2), 32'h3);
        check("add_reg1_cleared", ie_reg1, 32'h0);

        // Write-through of R2, then stored value of R2 plus write-through of R3
        write_back(4'd2, 32'h1234);
        tick();
        check("wt_reg1", ie_reg1, 32'h1234);
        write_back(4'd3, 32'h55);
        tick();
        check("stored_reg1", ie_reg1, 32'h1234);
        check("wt_reg2", ie_reg2, 32'h55);
        wb_en_in = 1'b0;

        // EX RAW on Rn
        issue(I_SUB_R4_R3_R5, 32'h10C);
        ex_wb_en = 1'b1;
        ex_dest  = 4'd3;
        #1;
        check("ex_raw_stall", 32'(hazard_stall), FWD ? 32'h0 : 32'h1);
        tick();
        check("ex_raw_valid", 32'(ie_valid), FWD ? 32'h1 : 32'h0);
        check("ex_raw_alu", 32'(ie_alu_cmd), FWD ? 32'h4 : 32'h0);
        ex_wb_en = 1'b0;
        #1;
        check("ex_clr_stall", 32'(hazard_stall), 32'h0);
        tick();
        check("sub_valid", 32'(ie_valid), 32'h1);
        check("sub_alu", 32'(ie_alu_cmd), 32'h4);
        check("sub_dest", 32'(ie_dest), 32'h4);
        check("sub_reg1", ie_reg1, 32'h55);

        // MEM RAW on Rm
        mem_wb_en = 1'b1;
        mem_dest  = 4'd5;
        #1;
        check("mem_raw_stall", 32'(hazard_stall), FWD ? 32'h0 : 32'h1);
        tick();
        check("mem_raw_valid", 32'(ie_valid), FWD ? 32'h1 : 32'h0);
        mem_wb_en = 1'b0;

        // Load-use against EX stalls in both builds
        ex_wb_en    = 1'b1;
        ex_mem_read = 1'b1;
        ex_dest     = 4'd3;
        #1;
        check("load_use_stall", 32'(hazard_stall), 32'h1);
        tick();
        check("load_use_valid", 32'(ie_valid), 32'h0);
        ex_mem_read = 1'b0;

        // MOVEQ: Rn=0 is not a used source, so EX dest 0 must not stall
        issue(I_MOVEQ_R1_5, 32'h110);
        ex_wb_en = 1'b1;
        ex_dest  = 4'd0;
        status   = 4'b0000;
        #1;
        check("mov_no_stall", 32'(hazard_stall), 32'h0);
        tick();
        check("moveq_f_valid", 32'(ie_valid), 32'h1);
        check("moveq_f_wb", 32'(ie_wb_en), 32'h0);
        check("moveq_f_alu", 32'(ie_alu_cmd), 32'h0);
        check("moveq_f_dest", 32'(ie_dest), 32'h1);
        status = 4'b0100;
        tick();
        check("moveq_t_alu", 32'(ie_alu_cmd), 32'h1);
        check("moveq_t_wb", 32'(ie_wb_en), 32'h1);
        check("moveq_t_imm", 32'(ie_imm), 32'h1);
        check("moveq_t_shop", 32'(ie_shift_op), 32'h005);
        ex_wb_en = 1'b0;

        // Condition 1111 never executes
        issue(I_ADDNV, 32'h114);
        tick();
        check("nv_valid", 32'(ie_valid), 32'h1);
        check("nv_alu", 32'(ie_alu_cmd), 32'h0);
        check("nv_wb", 32'(ie_wb_en), 32'h0);

        // TST with S=1
        issue(I_TSTS_R1_R2, 32'h118);
        tick();
        check("tst_alu", 32'(ie_alu_cmd), 32'h6);
        check("tst_wb", 32'(ie_wb_en), 32'h0);
        check("tst_status_en", 32'(ie_status_en), 32'h1);

        // Flush together with a hazard: flush wins, no stall
        issue(I_SUB_R4_R3_R5, 32'h11C);
        ex_wb_en    = 1'b1;
        ex_mem_read = 1'b1;
        ex_dest     = 4'd3;
        flush       = 1'b1;
        #1;
        check("flush_hz_stall", 32'(hazard_stall), 32'h0);
        tick();
        check("flush_valid", 32'(ie_valid), 32'h0);
        check("flush_wb", 32'(ie_wb_en), 32'h0);
        check("flush_alu", 32'(ie_alu_cmd), 32'h0);
        flush       = 1'b0;
        ex_wb_en    = 1'b0;
        ex_mem_read = 1'b0;

        // STR R7,[R2]
        issue(I_STR_R7_R2, 32'h120);
        tick();
        check("str_src2", 32'(ie_src2), 32'h7);
        check("str_mem_write", 32'(ie_mem_write), 32'h1);
        check("str_wb", 32'(ie_wb_en), 32'h0);
        check("str_alu", 32'(ie_alu_cmd), 32'h2);
        check("str_reg1", ie_reg1, 32'h1234);

        // LDR R7,[R2]
        issue(I_LDR_R7_R2, 32'h124);
        tick();
        check("ldr_mem_read", 32'(ie_mem_read), 32'h1);
        check("ldr_wb", 32'(ie_wb_en), 32'h1);
        check("ldr_src2", 32'(ie_src2), 32'h0);

        // Branch: neither source used, EX dest 0 must not stall
        issue(I_B_10, 32'h128);
        ex_wb_en = 1'b1;
        ex_dest  = 4'd0;
        #1;
        check("br_no_stall", 32'(hazard_stall), 32'h0);
        tick();
        check("br_branch", 32'(ie_branch), 32'h1);
        check("br_simm24", 32'(ie_simm24), 32'h10);
        check("br_wb", 32'(ie_wb_en), 32'h0);
        ex_wb_en = 1'b0;

        // Empty slot becomes a bubble
        in_valid = 1'b0;
        tick();
        check("idle_valid", 32'(ie_valid), 32'h0);
        check("idle_branch", 32'(ie_branch), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
